// File: rtl/fetch_unit.sv
// fetch_unit - instruction-fetch front end for the pipelined ARM core.
//
// Holds the program counter and picks the next PC each edge. The priority is
// halt > stall > taken branch > increment. It drives the ROM address and hands
// the ROM word to the core. The word is replaced by NOP_WORD and instr_valid is
// dropped while the unit is flushing after a branch or is halted.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   defined   -> 16-bit saturating stall/branch event counters
//   undefined -> no counter flops, stall_cnt/branch_cnt read 0
//
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous, active-high
//   halt_req      freeze fetch (acts at next edge)
//   stall_enable  hazard redirect request, target pc_stall
//   pc_src        taken-branch redirect request, target pc_branch
//   rom_instr     ROM data, combinational from pc
//   pc            registered PC
//   instruction   word to core (NOP_WORD during bubbles)
//   instr_valid   instruction is a real fetched word
//   stall_cnt     accepted stall cycles
//   branch_cnt    accepted taken branches
module fetch_unit #(
    parameter int                  PC_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  FLUSH_DEPTH = 1,   // 0..15
    parameter logic [31:0]         NOP_WORD    = 32'hD503201F
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                halt_req,
    input  logic                stall_enable,
    input  logic [PC_WIDTH-1:0] pc_stall,
    input  logic                pc_src,
    input  logic [PC_WIDTH-1:0] pc_branch,
    input  logic [31:0]         rom_instr,
    output logic [PC_WIDTH-1:0] pc,
    output logic [31:0]         instruction,
    output logic                instr_valid,
    output logic [15:0]         stall_cnt,
    output logic [15:0]         branch_cnt
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_DEPTH);

    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

    state_t              state, state_nxt;
    logic [3:0]          flush_cnt, flush_nxt;
    logic [PC_WIDTH-1:0] pc_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            flush_cnt <= '0;
            pc        <= RESET_PC;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_nxt;
            pc        <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        flush_nxt = flush_cnt;
        pc_nxt    = pc;
        if (halt_req) begin
            // Freeze. The flush count is kept, but it is discarded on release.
            state_nxt = HALT;
        end else if (state == HALT) begin
            // Release: resume at the held PC. Redirects seen on this edge are ignored.
            state_nxt = RUN;
            flush_nxt = '0;
        end else if (stall_enable) begin
            // Stall wins over a simultaneous branch. The flush count is held.
            pc_nxt = pc_stall;
        end else if (pc_src) begin
            pc_nxt = pc_branch;
            if (FLUSH_DEPTH > 0) begin
                state_nxt = FLUSH;
                flush_nxt = FLUSH_LOAD;
            end
        end else begin
            pc_nxt = pc + PC_WIDTH'(1);
            if (state == FLUSH) begin
                if (flush_cnt <= 4'd1) begin
                    flush_nxt = '0;
                    state_nxt = RUN;
                end else begin
                    flush_nxt = flush_cnt - 4'd1;
                end
            end
        end
    end

    always_comb begin
        instruction = NOP_WORD;
        instr_valid = 1'b0;
        if (state == RUN) begin
            instruction = rom_instr;
            instr_valid = 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // A request counts only when it actually redirects the PC. That excludes
    // halt cycles, the release edge, and a branch that loses to a stall.
    logic stall_acc, branch_acc;
    assign stall_acc  = !halt_req && (state != HALT) && stall_enable;
    assign branch_acc = !halt_req && (state != HALT) && !stall_enable && pc_src;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt  <= '0;
            branch_cnt <= '0;
        end else begin
            if (stall_acc && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if (branch_acc && (branch_cnt != 16'hFFFF))
                branch_cnt <= branch_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt  = '0;
    assign branch_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int FD = 1;
    localparam logic [31:0] NOP = 32'hD503201F;
    localparam logic [31:0] ROM_KEY = 32'h5A5A_0000;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        halt_req = 1'b0, stall_enable = 1'b0, pc_src = 1'b0;
    logic [31:0] pc_stall = '0, pc_branch = '0;
    logic [31:0] rom_instr, pc, instruction;
    logic        instr_valid;
    logic [15:0] stall_cnt, branch_cnt;

    // The ROM contents are a fixed function of the address.
    assign rom_instr = pc ^ ROM_KEY;

    always #5 clock = ~clock;

    fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0), .FLUSH_DEPTH(FD), .NOP_WORD(NOP)) dut (
        .clock(clock), .reset(reset), .halt_req(halt_req),
        .stall_enable(stall_enable), .pc_stall(pc_stall),
        .pc_src(pc_src), .pc_branch(pc_branch), .rom_instr(rom_instr),
        .pc(pc), .instruction(instruction), .instr_valid(instr_valid),
        .stall_cnt(stall_cnt), .branch_cnt(branch_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        vld;
        logic [15:0] sc;
        logic [15:0] bc;
    } exp_t;

    exp_t sbq[$];

    int n_chk = 0, n_fail = 0;

    // Reference model state: 0 run, 1 flush, 2 halt
    logic [31:0] m_pc;
    int          m_st, m_fc;
    logic [15:0] m_sc, m_bc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_st = 0; m_fc = 0; m_sc = 16'h0; m_bc = 16'h0;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.pc    = m_pc;
        e.vld   = (m_st == 0);
        e.instr = e.vld ? (m_pc ^ ROM_KEY) : NOP;
        e.sc    = PERF ? m_sc : 16'h0;
        e.bc    = PERF ? m_bc : 16'h0;
        return e;
    endfunction

    task automatic model_step(input logic h, input logic s, input logic [31:0] ps,
                              input logic b, input logic [31:0] pb);
        if (h) m_st = 2;
        else if (m_st == 2) begin m_st = 0; m_fc = 0; end
        else if (s) begin
            m_pc = ps;
            if (m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
        end else if (b) begin
            m_pc = pb;
            if (m_bc != 16'hFFFF) m_bc = m_bc + 16'd1;
            if (FD > 0) begin m_st = 1; m_fc = FD; end
        end else begin
            m_pc = m_pc + 32'd1;
            if (m_st == 1) begin
                m_fc = m_fc - 1;
                if (m_fc <= 0) begin m_fc = 0; m_st = 0; end
            end
        end
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sbq.pop_front();
        chk({tag, "_pc"},    64'(pc),          64'(e.pc));
        chk({tag, "_vld"},   64'(instr_valid), 64'(e.vld));
        chk({tag, "_instr"}, 64'(instruction), 64'(e.instr));
        chk({tag, "_scnt"},  64'(stall_cnt),   64'(e.sc));
        chk({tag, "_bcnt"},  64'(branch_cnt),  64'(e.bc));
    endtask

    // Drive one cycle of requests, push the expected post-edge outputs, then
    // sample 1 time unit after the edge and compare.
    task automatic cyc(input string tag, input logic h, input logic s, input logic [31:0] ps,
                       input logic b, input logic [31:0] pb);
        halt_req = h; stall_enable = s; pc_stall = ps; pc_src = b; pc_branch = pb;
        model_step(h, s, ps, b, pb);
        sbq.push_back(model_out());
        @(posedge clock);
        #1;
        compare_out(tag);
    endtask

    initial begin
        model_reset();
        #1;
        sbq.push_back(model_out());
        compare_out("reset");
        #11 reset = 1'b0;   // released between edges (t=12)

        // Straight-line fetch 0..4
        for (int i = 1; i <= 4; i++) begin
            cyc("seq", 0, 0, 0, 0, 0);
            chk("seq_pc_const", 64'(pc), 64'(i));
        end

        // Branch at pc=3 with one bubble
        sbq.push_back(model_out());
        compare_out("pre_br");
        stall_enable = 1'b1; pc_stall = 32'h3;   // rewind to 3 first
        cyc("rewind", 0, 1, 32'h3, 0, 0);
        cyc("br", 0, 0, 0, 1, 32'h40);
        chk("br_pc", 64'(pc), 64'h40);
        chk("br_bubble", 64'(instr_valid), 64'd0);
        chk("br_nop", 64'(instruction), 64'hD503201F);
        cyc("br_next", 0, 0, 0, 0, 0);
        chk("br_next_pc", 64'(pc), 64'h41);
        chk("br_next_vld", 64'(instr_valid), 64'd1);
        chk("br_cnt_1", 64'(branch_cnt), PERF ? 64'd1 : 64'd0);

        // Stall beats a simultaneous branch
        cyc("stall_br", 0, 1, 32'h5, 1, 32'h80);
        chk("stall_br_pc", 64'(pc), 64'h5);
        chk("stall_br_bcnt", 64'(branch_cnt), PERF ? 64'd1 : 64'd0);

        // Halt at pc=7 for 3 cycles, stall pulsed in the middle
        cyc("to7", 0, 0, 0, 0, 0);
        cyc("to7", 0, 0, 0, 0, 0);
        chk("halt_start_pc", 64'(pc), 64'h7);
        cyc("halt", 1, 0, 0, 0, 0);
        cyc("halt", 1, 1, 32'h99, 0, 0);
        cyc("halt", 1, 0, 0, 1, 32'h55);
        chk("halt_pc", 64'(pc), 64'h7);
        chk("halt_vld", 64'(instr_valid), 64'd0);
        cyc("release", 0, 1, 32'h99, 0, 0);   // stall on release edge is ignored
        chk("release_pc", 64'(pc), 64'h7);
        chk("release_vld", 64'(instr_valid), 64'd1);
        cyc("resume", 0, 0, 0, 0, 0);
        chk("resume_pc", 64'(pc), 64'h8);

        // Stall inside FLUSH holds the bubble; branch in FLUSH reloads it
        cyc("fl_br", 0, 0, 0, 1, 32'h100);
        cyc("fl_stall", 0, 1, 32'h200, 0, 0);
        chk("fl_stall_vld", 64'(instr_valid), 64'd0);
        cyc("fl_rebr", 0, 0, 0, 1, 32'h300);
        cyc("fl_exit", 0, 0, 0, 0, 0);
        chk("fl_exit_vld", 64'(instr_valid), 64'd1);

        // PC wrap
        cyc("wrap_set", 0, 1, 32'hFFFF_FFFF, 0, 0);
        cyc("wrap", 0, 0, 0, 0, 0);
        chk("wrap_pc", 64'(pc), 64'h0);

        // Random mix
        for (int i = 0; i < 400; i++) begin
            logic h, s, b;
            h = ($urandom_range(0, 9) == 0);
            s = ($urandom_range(0, 5) == 0);
            b = ($urandom_range(0, 3) == 0);
            cyc("rand", h, s, $urandom, b, $urandom);
        end

        // Reset asserted mid-cycle while in FLUSH
        cyc("pre_rst", 0, 0, 0, 0, 0);
        cyc("rst_br", 0, 0, 0, 1, 32'h1234);
        chk("rst_in_flush", 64'(instr_valid), 64'd0);
        halt_req = 0; stall_enable = 0; pc_src = 0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        sbq.push_back(model_out());
        compare_out("mid_rst");
        chk("mid_rst_pc", 64'(pc), 64'h0);
        chk("mid_rst_vld", 64'(instr_valid), 64'd1);
        #2 reset = 1'b0;
        cyc("post_rst", 0, 0, 0, 0, 0);
        chk("post_rst_pc", 64'(pc), 64'h1);

`ifdef FETCH_PERF_CNT_EN
        for (int i = 0; i < 70000; i++) begin
            halt_req = 0; stall_enable = 1; pc_stall = 32'h20; pc_src = 0;
            model_step(0, 1, 32'h20, 0, 0);
            @(posedge clock);
        end
        #1;
        chk("stall_sat", 64'(stall_cnt), 64'hFFFF);
        sbq.push_back(model_out());
        compare_out("sat");
`else
        cyc("nocnt", 0, 1, 32'h20, 1, 32'h30);
        chk("nocnt_s", 64'(stall_cnt), 64'd0);
        chk("nocnt_b", 64'(branch_cnt), 64'd0);
`endif

        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end for the pipelined ARM core. Owns the program counter, resolves the core's stall (`hazard_pc_write`/`hazard_pc_out`) and branch (`ctrl_branch_out`/`branch_pc_out`) redirect requests, and drives the ROM address. Returns the ROM word to the core, with bubbles for post-branch flush and halt. Replaces the PC-update logic currently open-coded in the CPU testbench.

## Interface
Parameters:
- `PC_WIDTH`, 32, width of PC and redirect targets
- `RESET_PC`, 0, PC value loaded on reset
- `FLUSH_DEPTH`, 1, bubble cycles issued after a taken branch (0 = none; max 15)
- `NOP_WORD`, 32'hD503201F, ARMv8 NOP substituted for bubbles

Ports:
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `halt_req`  in  1  freeze fetch while high
- `stall_enable`  in  1  core hazard request (`hazard_pc_write`)
- `pc_stall`  in  PC_WIDTH  stall target (`hazard_pc_out`)
- `pc_src`  in  1  core taken-branch request (`ctrl_branch_out`)
- `pc_branch`  in  PC_WIDTH  branch target (`branch_pc_out`)
- `rom_instr`  in  32  ROM data, combinational from `pc`
- `pc`  out  PC_WIDTH  registered PC, to ROM address and core
- `instruction`  out  32  word to core
- `instr_valid`  out  1  high when `instruction` is a real fetched word
- `stall_cnt`  out  16  cycles with an accepted stall
- `branch_cnt`  out  16  accepted taken branches

## Operation
- FSM states: RUN, FLUSH, HALT. Reset state RUN.
- Next-PC priority per edge: halt > stall > branch > increment.
  - HALT or entering HALT: PC holds.
  - `stall_enable`=1: PC <= `pc_stall`; simultaneous `pc_src` dropped (not counted).
  - `pc_src`=1: PC <= `pc_branch`.
  - else PC <= PC+1, modulo 2^PC_WIDTH (all-ones wraps to 0, no flag).
- Transitions:
  - any -> HALT when `halt_req`=1.
  - HALT -> RUN when `halt_req`=0; flush counter cleared; stall/branch ignored during HALT.
  - RUN -> FLUSH on accepted branch if FLUSH_DEPTH>0; flush counter <= FLUSH_DEPTH.
  - FLUSH: counter decrements each non-stalled cycle; -> RUN on edge where counter reaches 0. Stall holds counter. Accepted branch reloads it to FLUSH_DEPTH.
- Outputs (combinational from state and `rom_instr`):
  - RUN: `instruction`=`rom_instr`, `instr_valid`=1.
  - FLUSH/HALT: `instruction`=NOP_WORD, `instr_valid`=0.
- Counters: 16-bit, saturate at 16'hFFFF, not cleared except by reset.

## Timing
- Reset (async, immediate): `pc`=RESET_PC, state RUN, flush counter 0, `stall_cnt`=`branch_cnt`=0; hence `instruction`=`rom_instr`, `instr_valid`=1.
- Redirect latency: request sampled at edge N, new `pc` visible after edge N; ROM word for it same cycle (zero-latency ROM).
- FLUSH_DEPTH=k: exactly k invalid cycles after the branch edge, absent stalls.
- `halt_req` acts at the next edge; release resumes at the held PC next cycle with `instr_valid`=1.
- Reset asserted mid-FLUSH or mid-HALT: immediate return to reset values; pending requests lost.

## Configuration
- `FETCH_PERF_CNT_EN`: defined -> `stall_cnt`/`branch_cnt` implemented as above. Undefined -> no counter flops; both outputs tied to 0. PC/FSM behaviour identical either way.

## Test plan
- Reset release, no requests, 5 cycles -> `pc` 0,1,2,3,4; `instr_valid`=1 throughout; counters 0.
- `pc_src`=1, `pc_branch`=0x40 at pc=3, FLUSH_DEPTH=1 -> next `pc`=0x40 with `instr_valid`=0, `instruction`=0xD503201F; then `pc`=0x41 valid; `branch_cnt`=1.
- `stall_enable`=1, `pc_stall`=5, `pc_src`=1, `pc_branch`=0x80 same edge -> `pc`=5, `stall_cnt`=1, `branch_cnt`=0.
- `halt_req` high 3 cycles at pc=7, stall pulsed meanwhile -> `pc` holds 7, `instr_valid`=0, `stall_cnt` unchanged; release -> `pc`=7 valid, then 8.
- PC=0xFFFFFFFF, no request -> next `pc`=0; assert `reset` mid-cycle during FLUSH -> `pc`=RESET_PC immediately, `instr_valid`=1.
- FETCH_PERF_CNT_EN defined, stall held 70000 cycles -> `stall_cnt`=0xFFFF; undefined -> counters read 0.
